alu_sequencer: RTL

- Multi-cycle initiator that sits between the processor control path and the 16-bit combinational ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU operand and opcode ports.
- Captures the ALU result and flags, and returns a registered response over a valid/ready handshake.
- Builds compound operations from ALU primitives: 16x16 multiply (low 16 bits) by shift-add, and signed set-less-than by subtract.

---
 rtl/alu_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle request/response sequencer driving a 16-bit combinational ALU
module alu_sequencer #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic             input_CLK,
    input  logic             input_Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [2:0]       req_aluop,
    input  logic [WIDTH-1:0] req_A,
    input  logic [WIDTH-1:0] req_B,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_negative,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_EXEC      = 3'd1;
    localparam logic [2:0] ST_SLT       = 3'd2;
    localparam logic [2:0] ST_MUL_ADD   = 3'd3;
    localparam logic [2:0] ST_MUL_SHIFT = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [1:0] CMD_MUL  = 2'b01;
    localparam logic [1:0] CMD_SLT  = 2'b10;
    localparam logic [1:0] CMD_RSVD = 2'b11;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_IDLE = 3'b111;

    localparam int CW = $clog2(MUL_STEPS) + 1;

    logic [2:0]       state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [2:0]       aluop_q, aluop_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             slt_ovf;
    logic             slt_lt;

    // Signed compare: the sign of A-B is wrong exactly when the subtraction overflowed.
    always_comb begin
        slt_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_q[WIDTH-1]);
        slt_lt  = alu_negative ^ slt_ovf;
    end

    // Next-state, datapath and ALU drive; the ALU is parked at idle/zero unless a step needs it.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        aluop_d  = aluop_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        res_d    = res_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        alu_A    = '0;
        alu_B    = '0;
        alu_op   = OP_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cmd_d   = req_cmd;
                    aluop_d = req_aluop;
                    a_d     = req_A;
                    b_d     = req_B;
                    if (req_cmd == CMD_MUL) begin
                        acc_d    = '0;
                        mcand_d  = req_A;
                        mplier_d = req_B;
                        count_d  = '0;
                        state_d  = ST_MUL_ADD;
                    end else if (req_cmd == CMD_SLT) begin
                        state_d = ST_SLT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                alu_A = a_q;
                alu_B = b_q;
                if (cmd_q == CMD_RSVD) begin
                    res_d  = '0;
                    zero_d = 1'b1;
                    neg_d  = 1'b0;
                end else begin
                    alu_op = aluop_q;
                    res_d  = alu_result;
                    zero_d = alu_zero;
                    neg_d  = alu_negative;
                end
                state_d = ST_DONE;
            end
            ST_SLT: begin
                alu_A   = a_q;
                alu_B   = b_q;
                alu_op  = OP_SUB;
                res_d   = {{(WIDTH-1){1'b0}}, slt_lt};
                zero_d  = ~slt_lt;
                neg_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_MUL_ADD: begin
                alu_A  = acc_q;
                alu_B  = mcand_q;
                alu_op = OP_ADD;
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                state_d = ST_MUL_SHIFT;
            end
            ST_MUL_SHIFT: begin
                alu_A    = mcand_q;
                alu_B    = {{(WIDTH-1){1'b0}}, 1'b1};
                alu_op   = OP_SHL;
                mcand_d  = alu_result;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(MUL_STEPS - 1)) begin
                    res_d   = acc_q;
                    zero_d  = (acc_q == '0);
                    neg_d   = acc_q[WIDTH-1];
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL_ADD;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge input_CLK) begin
        if (input_Reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            aluop_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            aluop_q  <= aluop_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    // Handshake outputs follow the state; the response fields come straight from registers.
    always_comb begin
        req_ready     = (state_q == ST_IDLE);
        resp_valid    = (state_q == ST_DONE);
        resp_result   = res_q;
        resp_zero     = zero_q;
        resp_negative = neg_q;
    end

endmodule
